data_checker: RTL and testbench

//  Receive-side checker for the incrementing 32-bit data stream (valid + data), placed at the far end
//  of the RAM path. Frames the stream into PKT_LEN-word packets and compares every word with an expected

---
 rtl/data_checker.sv | 156 +++++++++++++++
 tb/tb_data_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_checker.sv
`default_nettype none
// ============================================================================
// data_checker : frames an incrementing 32-bit stream into packets and checks
//                each word against an expected counter. Rev 1.0
// ============================================================================
module data_checker #(
  parameter int PKT_LEN = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_data_valid,
  input  logic [31:0]      i_data,
  output logic             o_busy,
  output logic             o_pkt_done,
  output logic             o_pkt_pass,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_first_err_vld,
  output logic [31:0]      o_first_err_exp,
  output logic [31:0]      o_first_err_got
);

  localparam logic [15:0] c_LAST_IDX = 16'(PKT_LEN - 1);
  localparam logic [15:0] c_TMO_IDX  = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_exp;
  logic [15:0]      r_idx, r_idle;
  logic             r_perr, r_done, r_pass, r_to;
  logic [CNT_W-1:0] r_pkt_cnt, r_err_cnt;
  logic             r_fvld;
  logic [31:0]      r_fexp, r_fgot;

  logic w_acc, w_mis, w_last, w_tmo, w_done, w_pass, w_to;

  // A word presented together with i_clear is discarded entirely.
  assign w_acc  = i_data_valid & ~i_clear;
  assign w_mis  = w_acc & (i_data != r_exp);
  assign w_last = (r_state == S_RECV) & w_acc & (r_idx == c_LAST_IDX);
  assign w_tmo  = (r_state == S_RECV) & ~i_data_valid & ~i_clear & (r_idle == c_TMO_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_pass = 1'b0;
    w_to   = 1'b0;
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) w_next = S_RECV;
        S_RECV: begin
          if (w_last) begin
            w_next = S_IDLE;
            w_done = 1'b1;
            w_pass = ~(r_perr | w_mis);
          end else if (w_tmo) begin
            w_next = S_IDLE;
            w_done = 1'b1;
            w_to   = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp     <= '0;
      r_idx     <= '0;
      r_idle    <= '0;
      r_perr    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_to      <= 1'b0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
      r_fvld    <= 1'b0;
      r_fexp    <= '0;
      r_fgot    <= '0;
    end else if (i_clear) begin
      r_exp     <= '0;
      r_idx     <= '0;
      r_idle    <= '0;
      r_perr    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_to      <= 1'b0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
      r_fvld    <= 1'b0;
      r_fexp    <= '0;
      r_fgot    <= '0;
    end else begin
      if (w_acc) begin
        // No resync: expected advances on every accepted word.
        r_exp  <= r_exp + 32'd1;
        r_idle <= '0;
        if (r_state == S_IDLE) begin
          r_idx  <= 16'd1;
          r_perr <= w_mis;
        end else begin
          r_idx  <= w_last ? 16'd0 : r_idx + 16'd1;
          r_perr <= r_perr | w_mis;
        end
      end else if (r_state == S_RECV) begin
        if (w_tmo) begin
          r_idle <= '0;
          r_idx  <= '0;
        end else begin
          r_idle <= r_idle + 16'd1;
        end
      end

      r_done <= w_done;
      if (w_done) begin
        r_pass <= w_pass;
        r_to   <= w_to;
        if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end

      if (w_mis) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fvld) begin
          r_fvld <= 1'b1;
          r_fexp <= r_exp;
          r_fgot <= i_data;
        end
      end
    end
  end

  assign o_busy          = (r_state == S_RECV);
  assign o_pkt_done      = r_done;
  assign o_pkt_pass      = r_pass;
  assign o_timeout       = r_to;
  assign o_pkt_cnt       = r_pkt_cnt;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_vld = r_fvld;
  assign o_first_err_exp = r_fexp;
  assign o_first_err_got = r_fgot;

endmodule
`default_nettype wire

// File: tb/tb_data_checker.sv
`default_nettype none
// ============================================================================
// tb_data_checker : scoreboard bench for data_checker. Rev 1.0
// ============================================================================
module tb_data_checker;

  localparam int PKT_LEN = 64;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 6;

  logic             clk, rst_n, i_clear, i_data_valid;
  logic [31:0]      i_data;
  logic             o_busy, o_pkt_done, o_pkt_pass, o_timeout;
  logic [CNT_W-1:0] o_pkt_cnt, o_err_cnt;
  logic             o_first_err_vld;
  logic [31:0]      o_first_err_exp, o_first_err_got;

  data_checker #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear),
    .i_data_valid(i_data_valid), .i_data(i_data),
    .o_busy(o_busy), .o_pkt_done(o_pkt_done), .o_pkt_pass(o_pkt_pass),
    .o_timeout(o_timeout), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt),
    .o_first_err_vld(o_first_err_vld), .o_first_err_exp(o_first_err_exp),
    .o_first_err_got(o_first_err_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             pass;
    logic             to;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] err;
  } exp_t;

  exp_t q[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic [31:0]      m_exp;
  int               m_idx, m_idle;
  logic             m_perr;
  logic [CNT_W-1:0] m_pkts, m_errs;
  logic             m_fvld;
  logic [31:0]      m_fexp, m_fgot;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    m_exp = 0; m_idx = 0; m_idle = 0; m_perr = 0;
    m_pkts = 0; m_errs = 0; m_fvld = 0; m_fexp = 0; m_fgot = 0;
  endtask

  task automatic push_result(input logic pass, input logic to);
    exp_t e;
    m_pkts = sat_inc(m_pkts);
    e.pass = pass; e.to = to; e.cnt = m_pkts; e.err = m_errs;
    q.push_back(e);
  endtask

  task automatic model_word(input logic [31:0] d);
    logic mis;
    mis = (d != m_exp);
    if (mis) begin
      m_errs = sat_inc(m_errs);
      if (!m_fvld) begin m_fvld = 1; m_fexp = m_exp; m_fgot = d; end
    end
    m_exp  = m_exp + 1;
    m_perr = (m_idx == 0) ? mis : (m_perr | mis);
    m_idx++;
    m_idle = 0;
    if (m_idx == PKT_LEN) begin
      push_result(!m_perr, 1'b0);
      m_idx = 0;
    end
  endtask

  task automatic model_idle();
    if (m_idx != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        push_result(1'b0, 1'b1);
        m_idx = 0; m_idle = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    i_data_valid = v;
    i_data       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    model_word(d);
    drive(1'b1, d);
  endtask

  task automatic send_range(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) send_word(start + 32'(i));
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_idle();
      drive(1'b0, 32'h0);
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    drive(1'b1, 32'h1234_5678);
    i_clear = 1'b0;
    model_reset();
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkt_cnt"}, 32'(o_pkt_cnt), 32'(m_pkts));
    chk({tag, "_err_cnt"}, 32'(o_err_cnt), 32'(m_errs));
    chk({tag, "_fvld"},    32'(o_first_err_vld), 32'(m_fvld));
    chk({tag, "_fexp"},    o_first_err_exp, m_fexp);
    chk({tag, "_fgot"},    o_first_err_got, m_fgot);
  endtask

  // Scoreboard: every done pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && o_pkt_done) begin
      exp_t e;
      done_cyc.push_back(cyc);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_pass",    32'(o_pkt_pass), 32'(e.pass));
        chk("done_timeout", 32'(o_timeout),  32'(e.to));
        chk("done_pkt_cnt", 32'(o_pkt_cnt),  32'(e.cnt));
        chk("done_err_cnt", 32'(o_err_cnt),  32'(e.err));
        chk("done_busy",    32'(o_busy),     32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; i_clear = 1'b0; i_data_valid = 1'b0; i_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_stats("reset");
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_pkt_done), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0);

    // 1: single clean packet
    send_range(0, PKT_LEN);
    idle_cyc(3);
    check_stats("t1");

    // 2: two packets back-to-back
    n0 = done_cyc.size();
    send_range(64, PKT_LEN);
    send_range(128, PKT_LEN);
    idle_cyc(3);
    chk("t2_two_dones", 32'(done_cyc.size() - n0), 32'd2);
    if (done_cyc.size() - n0 == 2)
      chk("t2_spacing", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'(PKT_LEN));

    // 3: corrupted word 10, then a clean packet
    send_range(192, 10);
    send_word(32'hDEAD_BEEF);
    send_range(203, PKT_LEN - 11);
    send_range(256, PKT_LEN);
    idle_cyc(3);
    check_stats("t3");

    // 4: dropped word, then saturation of the error counter
    do_clear();
    check_stats("clr1");
    send_range(0, 5);
    send_range(6, PKT_LEN - 5);
    idle_cyc(3);
    check_stats("t4");
    send_range(0, PKT_LEN);
    idle_cyc(3);
    chk("t4_err_sat", 32'(o_err_cnt), 32'((1 << CNT_W) - 1));

    // 5: idle timeout then resume
    do_clear();
    send_range(0, 20);
    chk("t5_busy", 32'(o_busy), 32'd1);
    idle_cyc(TIMEOUT + 3);
    chk("t5_busy_after", 32'(o_busy), 32'd0);
    chk("t5_timeout_hold", 32'(o_timeout), 32'd1);
    send_range(20, PKT_LEN);
    idle_cyc(3);
    check_stats("t5");
    chk("t5_timeout_cleared", 32'(o_timeout), 32'd0);

    // 6: clear mid-packet, reset mid-packet, random gaps
    send_range(84, 30);
    do_clear();
    check_stats("t6_clr");
    chk("t6_clr_busy", 32'(o_busy), 32'd0);
    send_range(0, 40);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_stats("t6_rst");
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h0);
    for (int i = 0; i < PKT_LEN; i++) begin
      send_word(32'(i));
      idle_cyc($urandom_range(0, TIMEOUT - 2));
    end
    idle_cyc(3);
    check_stats("t6_gaps");
    chk("t6_pass", 32'(o_pkt_pass), 32'd1);

    idle_cyc(5);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
